// File: rtl/i2s_pkg.sv
// Shared types and default ratios for the I2S master clock generator.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } clkgen_state_t;

  localparam int I2S_MCLK_PER_SCLK  = 4;
  localparam int I2S_SCLK_PER_FRAME = 64;
  localparam int I2S_FRAME_CNT_W    = 16;

endpackage

// File: rtl/i2s_sclk_div.sv
// mclk-to-sclk phase counter with raw "next sclk edge" decode.
module i2s_sclk_div
  import i2s_pkg::*;
#(
  parameter int MCLK_PER_SCLK = I2S_MCLK_PER_SCLK
) (
  input  logic mclk,
  input  logic reset_n,
  input  logic step_i,
  output logic last_o,
  output logic half_o
);

  localparam int DIV_W = (MCLK_PER_SCLK > 1) ? $clog2(MCLK_PER_SCLK) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_PER_SCLK - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_PER_SCLK / 2 - 1);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (step_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // Parking at the last phase makes the first RUN cycle a frame-start cycle.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= DIV_LAST;
    end else begin
      div_q <= div_d;
    end
  end

  assign last_o = (div_q == DIV_LAST);
  assign half_o = (div_q == DIV_HALF);

endmodule

// File: rtl/i2s_clkgen.sv
// Master-mode I2S sclk/lrclk generator with frame-aligned start/stop.
// Optional frame counter built when I2S_CLKGEN_FRAME_CNT_EN is defined.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int MCLK_PER_SCLK  = I2S_MCLK_PER_SCLK,
  parameter int SCLK_PER_FRAME = I2S_SCLK_PER_FRAME
) (
  input  logic                       mclk,
  input  logic                       reset_n,
  input  logic                       i_enable,
  output logic                       o_sclk,
  output logic                       o_lrclk,
  output logic                       o_next_sclk_rise,
  output logic                       o_next_sclk_fall,
  output logic                       o_next_lrclk_rise,
  output logic                       o_next_lrclk_fall,
  output logic                       o_running,
  output logic [I2S_FRAME_CNT_W-1:0] o_frame_count
);

  localparam int BIT_W = $clog2(SCLK_PER_FRAME);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SCLK_PER_FRAME - 1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(SCLK_PER_FRAME / 2 - 1);

  clkgen_state_t    state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  logic             active, div_last, div_half, bit_last, bit_half;
  logic             stop_now, step;

  assign active   = (state_q == RUN) || (state_q == STOPPING);
  assign bit_last = (bit_cnt_q == BIT_LAST);
  assign bit_half = (bit_cnt_q == BIT_HALF);
  // Terminal cycle of a stopping frame: counters freeze and the frame-start strobe is withheld.
  assign stop_now = (state_q == STOPPING) && div_last && bit_last;
  assign step     = active && !stop_now;

  i2s_sclk_div #(
    .MCLK_PER_SCLK(MCLK_PER_SCLK)
  ) u_sclk_div (
    .mclk   (mclk),
    .reset_n(reset_n),
    .step_i (step),
    .last_o (div_last),
    .half_o (div_half)
  );

  assign o_next_sclk_rise  = active && div_half;
  assign o_next_sclk_fall  = step && div_last;
  assign o_next_lrclk_rise = step && div_last && bit_half;
  assign o_next_lrclk_fall = step && div_last && bit_last;
  assign o_running         = active;
  assign o_sclk            = sclk_q;
  assign o_lrclk           = lrclk_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    lrclk_d   = lrclk_q;
    unique case (state_q)
      IDLE:     if (i_enable) state_d = RUN;
      RUN:      if (!i_enable) state_d = STOPPING;
      STOPPING: begin
        if (stop_now) begin
          state_d = IDLE;
        end else if (i_enable) begin
          state_d = RUN;
        end
      end
      default:  state_d = IDLE;
    endcase
    if (step && div_last) begin
      bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
    end
    if (o_next_sclk_rise) sclk_d = 1'b1;
    // sclk still returns low on the terminal stop cycle even though its strobe is withheld.
    if (active && div_last) sclk_d = 1'b0;
    if (o_next_lrclk_rise) lrclk_d = 1'b1;
    if (o_next_lrclk_fall) lrclk_d = 1'b0;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= BIT_LAST;
      sclk_q    <= 1'b0;
      lrclk_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

`ifdef I2S_CLKGEN_FRAME_CNT_EN
  logic [I2S_FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (o_next_lrclk_fall) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_count = frame_cnt_q;
`else
  assign o_frame_count = '0;
`endif

endmodule

// File: tb/tb_i2s_clkgen.sv
// Scoreboard bench for i2s_clkgen: default ratios (dut_a) and 2/48 ratios (dut_b).
module tb_i2s_clkgen;
  import i2s_pkg::*;

  logic mclk = 1'b0;
  logic reset_n;
  logic en_a, en_b;

  logic a_sclk, a_lrclk, a_sr, a_sf, a_lr, a_lf, a_run;
  logic b_sclk, b_lrclk, b_sr, b_sf, b_lr, b_lf, b_run;
  logic [I2S_FRAME_CNT_W-1:0] a_fc, b_fc;

  i2s_clkgen dut_a (
    .mclk(mclk), .reset_n(reset_n), .i_enable(en_a),
    .o_sclk(a_sclk), .o_lrclk(a_lrclk),
    .o_next_sclk_rise(a_sr), .o_next_sclk_fall(a_sf),
    .o_next_lrclk_rise(a_lr), .o_next_lrclk_fall(a_lf),
    .o_running(a_run), .o_frame_count(a_fc)
  );

  i2s_clkgen #(.MCLK_PER_SCLK(2), .SCLK_PER_FRAME(48)) dut_b (
    .mclk(mclk), .reset_n(reset_n), .i_enable(en_b),
    .o_sclk(b_sclk), .o_lrclk(b_lrclk),
    .o_next_sclk_rise(b_sr), .o_next_sclk_fall(b_sf),
    .o_next_lrclk_rise(b_lr), .o_next_lrclk_fall(b_lf),
    .o_running(b_run), .o_frame_count(b_fc)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct packed {
    int dut;
    int kind;   // 0 = lrclk fall strobe, 1 = lrclk rise strobe
    int at;
    int fc;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  rise_cnt_a = 0;

  function automatic int exp_fc(input int v);
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    return v & 16'hFFFF;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int dut, input int kind, input int at, input int fc);
    ev_t e;
    e.dut = dut; e.kind = kind; e.at = at; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int dut, input int kind, input int fc);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: dut%0d kind%0d at cycle %0d fc %0d, expected no event", dut, kind, cyc, fc);
      return;
    end
    e = exp_q.pop_front();
    if (e.dut != dut || e.kind != kind || e.at != cyc || e.fc != fc) begin
      n_fail++;
      $display("FAIL sb_event: got dut%0d kind%0d cycle %0d fc %0d, expected dut%0d kind%0d cycle %0d fc %0d",
               dut, kind, cyc, fc, e.dut, e.kind, e.at, e.fc);
    end
  endtask

  always @(negedge mclk) begin
    if (a_lf) sb_pop(0, 0, int'(a_fc));
    if (a_lr) sb_pop(0, 1, int'(a_fc));
    if (b_lf) sb_pop(1, 0, int'(b_fc));
    if (b_lr) sb_pop(1, 1, int'(b_fc));
    if (a_sr) rise_cnt_a++;
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge mclk);
      #2;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, f, s, r, q, b0, rc0, rc1, viol;
    reset_n = 1'b0;
    en_a    = 1'b0;
    en_b    = 1'b0;

    goto(3);
    check("rst_sclk", int'(a_sclk), 0);
    check("rst_lrclk", int'(a_lrclk), 1);
    check("rst_running", int'(a_run), 0);
    check("rst_fc", int'(a_fc), 0);
    check("rst_strobes", int'({a_sr, a_sf, a_lr, a_lf}), 0);
    reset_n = 1'b1;
    goto(5);
    check("idle_lrclk", int'(a_lrclk), 1);
    check("idle_strobes", int'({a_sr, a_sf, a_lr, a_lf}), 0);

    // Start and free run five frames.
    t0 = 10;
    goto(t0);
    en_a = 1'b1;
    push(0, 0, t0 + 1, exp_fc(0));
    for (int k = 0; k < 5; k++) begin
      push(0, 1, t0 + 129 + 256 * k, exp_fc(k + 1));
      if (k < 4) push(0, 0, t0 + 257 + 256 * k, exp_fc(k + 1));
    end
    goto(t0 + 1);
    check("start_running", int'(a_run), 1);
    rc0 = rise_cnt_a;
    goto(t0 + 2);
    check("start_lrclk_low", int'(a_lrclk), 0);
    goto(t0 + 3);
    check("start_sclk_rise_strobe", int'(a_sr), 1);
    goto(t0 + 4);
    check("start_sclk_high", int'(a_sclk), 1);
    goto(t0 + 5);
    check("start_fc", int'(a_fc), exp_fc(1));
    goto(t0 + 6);
    check("sclk_low_half", int'(a_sclk), 0);
    goto(t0 + 8);
    check("sclk_period", int'(a_sclk), 1);
    goto(t0 + 129);
    check("lrclk_left_half", int'(a_lrclk), 0);
    goto(t0 + 130);
    check("lrclk_right_half", int'(a_lrclk), 1);
    goto(t0 + 1025);
    check("fc_after_4_frames", int'(a_fc), exp_fc(4));
    check("sclk_rises_4_frames", rise_cnt_a - rc0, 256);

    // Stop requested mid-frame: finish the frame, no frame-start strobe.
    f = t0 + 1025;
    goto(f + 60);
    en_a = 1'b0;
    goto(f + 100);
    check("stopping_running", int'(a_run), 1);
    goto(f + 256);
    check("stop_terminal_sclk_fall", int'(a_sf), 0);
    check("stop_terminal_lrclk", int'(a_lrclk), 1);
    goto(f + 257);
    check("stopped_running", int'(a_run), 0);
    check("stopped_lrclk", int'(a_lrclk), 1);
    check("stopped_sclk", int'(a_sclk), 0);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      goto(f + 257 + i);
      viol += int'(a_sr) + int'(a_sf) + int'(a_lr) + int'(a_lf);
    end
    check("idle_no_strobes", viol, 0);

    // Deassert and reassert inside one frame: keeps running undisturbed.
    s = f + 300;
    goto(s);
    en_a = 1'b1;
    push(0, 0, s + 1, exp_fc(5));
    push(0, 1, s + 129, exp_fc(6));
    push(0, 0, s + 257, exp_fc(6));
    push(0, 1, s + 385, exp_fc(7));
    goto(s + 1);
    rc1 = rise_cnt_a;
    goto(s + 50);
    en_a = 1'b0;
    goto(s + 60);
    check("glitch_stopping_running", int'(a_run), 1);
    goto(s + 80);
    en_a = 1'b1;
    goto(s + 257);
    check("glitch_sclk_rises", rise_cnt_a - rc1, 64);
    goto(s + 300);
    en_a = 1'b0;
    goto(s + 514);
    check("glitch_stop_running", int'(a_run), 0);
    check("glitch_stop_lrclk", int'(a_lrclk), 1);

    // Asynchronous reset mid-frame, then restart.
    r = s + 540;
    goto(r);
    en_a = 1'b1;
    push(0, 0, r + 1, exp_fc(7));
    goto(r + 2);
    check("pre_reset_lrclk", int'(a_lrclk), 0);
    goto(r + 40);
    #1;
    reset_n = 1'b0;
    en_a    = 1'b0;
    #1;
    check("async_rst_sclk", int'(a_sclk), 0);
    check("async_rst_lrclk", int'(a_lrclk), 1);
    check("async_rst_running", int'(a_run), 0);
    check("async_rst_fc", int'(a_fc), 0);
    check("async_rst_strobes", int'({a_sr, a_sf, a_lr, a_lf}), 0);
    goto(r + 45);
    reset_n = 1'b1;
    q = r + 50;
    goto(q);
    en_a = 1'b1;
    push(0, 0, q + 1, exp_fc(0));
    push(0, 1, q + 129, exp_fc(1));
    goto(q + 2);
    check("restart_lrclk_low", int'(a_lrclk), 0);
    goto(q + 4);
    check("restart_sclk_high", int'(a_sclk), 1);
    goto(q + 5);
    check("restart_fc", int'(a_fc), exp_fc(1));
    goto(q + 10);
    en_a = 1'b0;
    goto(q + 258);
    check("restart_stop_running", int'(a_run), 0);

    // Short ratio instance with frame counter wrap.
    b0 = q + 300;
`ifdef I2S_CLKGEN_FRAME_CNT_EN
    goto(b0 - 5);
    force dut_b.frame_cnt_q = 16'hFFFF;
    goto(b0 - 4);
    release dut_b.frame_cnt_q;
`endif
    goto(b0);
    en_b = 1'b1;
    push(1, 0, b0 + 1, exp_fc(16'hFFFF));
    push(1, 1, b0 + 49, exp_fc(0));
    push(1, 0, b0 + 97, exp_fc(0));
    push(1, 1, b0 + 145, exp_fc(1));
    goto(b0 + 2);
    check("b_fc_wrap", int'(b_fc), exp_fc(0));
    check("b_lrclk_low", int'(b_lrclk), 0);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      goto(b0 + 2 + i);
      if ((b_sr ^ b_sf) !== 1'b1 || b_sr !== ((i % 2) == 0)) viol++;
    end
    check("b_sclk_strobe_alternate", viol, 0);
    goto(b0 + 100);
    en_b = 1'b0;
    goto(b0 + 193);
    check("b_terminal_lrclk_fall", int'(b_lf), 0);
    goto(b0 + 194);
    check("b_stopped_running", int'(b_run), 0);
    check("b_stopped_lrclk", int'(b_lrclk), 1);
    check("b_stopped_sclk", int'(b_sclk), 0);
    check("b_fc_final", int'(b_fc), exp_fc(1));

    goto(b0 + 200);
    check("sb_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
